// File: rtl/stream_arb_pkg.sv
// -----------------------------------------------------------------------------
// stream_arb_pkg
// Shared types and helpers for the round-robin stream arbiter.
//   state_t  : arbiter state (IDLE = free to arbitrate, LOCKED = mid-packet)
//   src_size : width of a source-index field for n requesters
//   rr_pick  : round-robin search for the first valid requester at/after ptr
// -----------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Largest supported requester count; rr_pick works on vectors of this size.
    localparam int unsigned MAX_INPUTS = 16;

    function automatic int unsigned src_size(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Returns the first index with valid set, searching ptr, ptr+1, ... modulo n.
    // If nothing is valid the result is ptr; callers qualify it with |valid.
    function automatic logic [3:0] rr_pick(input logic [15:0]  valid,
                                           input logic [3:0]   ptr,
                                           input int unsigned  n);
        logic [3:0]  res;
        logic        found;
        int unsigned idx;
        res   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_INPUTS; k++) begin
            if (!found && (k < n)) begin
                idx = 32'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[3:0]]) begin
                    res   = idx[3:0];
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/one_stage_buffer.sv
// -----------------------------------------------------------------------------
// one_stage_buffer
// Single-entry registered valid/ready stage. Accepts a new word whenever it is
// empty or its current word is leaving in the same cycle, so it sustains one
// word per cycle with one cycle of latency.
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset
//   s_valid_i/s_ready_o    upstream handshake, s_data_i upstream word
//   m_valid_o/m_ready_i    downstream handshake, m_data_o stored word
// -----------------------------------------------------------------------------
module one_stage_buffer #(
    parameter int G_DATA_SIZE = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [G_DATA_SIZE-1:0] s_data_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [G_DATA_SIZE-1:0] m_data_o
);

    assign s_ready_o = !m_valid_o || m_ready_i;

    // Stage boundary: input handshake -> stored word (_p0 equivalent)
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
        end else if (s_valid_i && s_ready_o) begin
            m_valid_o <= 1'b1;
            m_data_o  <= s_data_i;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// stream_rr_arbiter
// Packet-aware round-robin merge of G_NUM_INPUTS valid/ready streams into one
// registered output stream. A source that starts a multi-beat packet keeps the
// grant until its last beat is accepted; the pointer then moves past it.
// Ports:
//   clk_i, rstn_i                      clock, synchronous active-low reset
//   s_valid_i, s_ready_o, s_data_i,    per-requester streams (data packed,
//   s_last_i                            requester i at [i*G_DATA_SIZE +: ...])
//   m_valid_o, m_ready_i, m_data_o,    merged output stream
//   m_last_o, m_src_o                   m_src_o = index of producing requester
// -----------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int G_NUM_INPUTS = 4,
    parameter int G_DATA_SIZE  = 8,
    parameter int G_SRC_SIZE   = src_size(G_NUM_INPUTS)
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [G_NUM_INPUTS-1:0]            s_valid_i,
    output logic [G_NUM_INPUTS-1:0]            s_ready_o,
    input  logic [G_NUM_INPUTS*G_DATA_SIZE-1:0] s_data_i,
    input  logic [G_NUM_INPUTS-1:0]            s_last_i,
    output logic                               m_valid_o,
    input  logic                               m_ready_i,
    output logic [G_DATA_SIZE-1:0]             m_data_o,
    output logic                               m_last_o,
    output logic [G_SRC_SIZE-1:0]              m_src_o
);

    localparam int BUF_W = G_DATA_SIZE + 1 + G_SRC_SIZE;
    localparam logic [G_SRC_SIZE-1:0] LAST_IDX = G_SRC_SIZE'(G_NUM_INPUTS - 1);

    state_t                  state;
    logic [G_SRC_SIZE-1:0]   rr_ptr;
    logic [G_SRC_SIZE-1:0]   lock_src;
    logic [G_SRC_SIZE-1:0]   grant;
    logic [15:0]             valid_ext;
    logic [3:0]              ptr_ext;
    logic [3:0]              pick;
    logic                    any_req;
    logic                    buf_ready;
    logic                    accept;
    logic [G_DATA_SIZE-1:0]  sel_data;
    logic                    sel_last;
    logic [BUF_W-1:0]        buf_in;
    logic [BUF_W-1:0]        buf_out;

    // Wrapping increment; never produces a value >= G_NUM_INPUTS.
    function automatic logic [G_SRC_SIZE-1:0] next_idx(input logic [G_SRC_SIZE-1:0] x);
        return (x == LAST_IDX) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        valid_ext                   = '0;
        valid_ext[G_NUM_INPUTS-1:0] = s_valid_i;
        ptr_ext                     = '0;
        ptr_ext[G_SRC_SIZE-1:0]     = rr_ptr;
    end

    assign pick = rr_pick(valid_ext, ptr_ext, G_NUM_INPUTS);

    // While locked the owner is granted even through idle gaps, so it must not
    // be qualified by its own valid; in IDLE a grant only exists when someone asks.
    always_comb begin
        if (state == LOCKED) begin
            grant   = lock_src;
            any_req = 1'b1;
        end else begin
            grant   = pick[G_SRC_SIZE-1:0];
            any_req = |s_valid_i;
        end
    end

    always_comb begin
        s_ready_o = '0;
        if (rstn_i && any_req) begin
            s_ready_o[grant] = buf_ready;
        end
    end

    always_comb begin
        sel_data = s_data_i[int'(grant)*G_DATA_SIZE +: G_DATA_SIZE];
        sel_last = s_last_i[grant];
        accept   = s_valid_i[grant] && s_ready_o[grant];
        buf_in   = {grant, sel_last, sel_data};
    end

    // Stage boundary: arbitration state updates on accepted beats
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_src <= '0;
        end else if (accept) begin
            if (sel_last) begin
                rr_ptr <= next_idx(grant);
                state  <= IDLE;
            end else if (state == IDLE) begin
                lock_src <= grant;
                state    <= LOCKED;
            end
        end
    end

    // Stage boundary: accepted beat -> registered output word
    one_stage_buffer #(
        .G_DATA_SIZE(BUF_W)
    ) u_buf (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .s_valid_i(accept),
        .s_ready_o(buf_ready),
        .s_data_i (buf_in),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_data_o (buf_out)
    );

    assign m_src_o  = buf_out[BUF_W-1 -: G_SRC_SIZE];
    assign m_last_o = buf_out[G_DATA_SIZE];
    assign m_data_o = buf_out[G_DATA_SIZE-1:0];

endmodule
